// File: rtl/ifid_skid_queue_pkg.sv
// ifid_skid_queue_pkg: shared IF/ID constants and the queue entry type
package ifid_skid_queue_pkg;

    localparam int dw = 64;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [dw-1:0] pc;
        logic [31:0]   inst;
        logic          fault;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_skid_queue_ptr_ctrl.sv
// ifid_ptr_ctrl: read/write pointers, occupancy count and registered f_ready
module ifid_ptr_ctrl
    import ifid_skid_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_valid,
    input  logic          d_ready,
    input  logic          flush,
    output logic          f_ready,
    output logic          enq,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count
);

    logic          deq;
    logic [CW-1:0] count_next;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // flush drops a same-cycle enqueue; a same-cycle dequeue is simply absorbed
    assign enq = f_valid & f_ready & ~flush;
    assign deq = (count != '0) & d_ready;

    always_comb count_next = flush ? '0 : count + CW'(enq) - CW'(deq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            f_ready <= 1'b1;
        end else begin
            wr_ptr  <= flush ? '0 : (enq ? wrap_inc(wr_ptr) : wr_ptr);
            rd_ptr  <= flush ? '0 : (deq ? wrap_inc(rd_ptr) : rd_ptr);
            count   <= count_next;
            f_ready <= count_next < CW'(DEPTH);
        end
    end

endmodule

// File: rtl/ifid_skid_queue.sv
// ifid_skid_queue: DEPTH-entry IF/ID valid/ready queue with registered f_ready
// Defining IFID_PERF_EN adds saturating stall/full/flush performance counters
module ifid_skid_queue
    import ifid_skid_queue_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_valid,
    output logic            f_ready,
    input  logic [XLEN-1:0] f_pc,
    input  logic [ILEN-1:0] f_inst,
    input  logic            f_fault,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [XLEN-1:0] d_pc,
    output logic [ILEN-1:0] d_inst,
    output logic            d_fault,
    input  logic            flush
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_full,
    output logic [31:0]     perf_flush
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic          enq;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    ifid_entry_t   mem [DEPTH];
    ifid_entry_t   head;

    ifid_ptr_ctrl #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .f_valid (f_valid),
        .d_ready (d_ready),
        .flush   (flush),
        .f_ready (f_ready),
        .enq     (enq),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .count   (count)
    );

    // storage is intentionally unreset; only slots covered by count are ever shown
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= '{pc: dw'(f_pc), inst: 32'(f_inst), fault: f_fault};
    end

    assign head    = mem[rd_ptr];
    assign d_valid = count != '0;
    assign d_pc    = d_valid ? head.pc[XLEN-1:0] : '0;
    assign d_inst  = d_valid ? head.inst[ILEN-1:0] : ILEN'(NOP_INST);
    assign d_fault = d_valid & head.fault;

`ifdef IFID_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic hit);
        return (hit && v != '1) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall <= '0;
            perf_full  <= '0;
            perf_flush <= '0;
        end else begin
            perf_stall <= sat_inc(perf_stall, d_valid & ~d_ready);
            perf_full  <= sat_inc(perf_full, count == CW'(DEPTH));
            perf_flush <= sat_inc(perf_flush, flush & d_valid);
        end
    end
`endif

endmodule

// File: tb/tb_ifid_skid_queue.sv
// tb_ifid_skid_queue: queue-model check of DEPTH=2 and DEPTH=3 instances
module tb_ifid_skid_queue;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;
    typedef ent_t ent_q_t[$];

    logic        clk = 0, rst = 0, f_valid = 0, d_ready = 0, f_fault = 0, flush = 0;
    logic [63:0] f_pc = 0;
    logic [31:0] f_inst = 0;
    logic        r2_ready, d2_valid, d2_fault, r3_ready, d3_valid, d3_fault;
    logic [63:0] d2_pc, d3_pc;
    logic [31:0] d2_inst, d3_inst;
`ifdef IFID_PERF_EN
    logic [31:0] p2_stall, p2_full, p2_flush, p3_stall, p3_full, p3_flush;
`endif

    int     tests = 0, fails = 0;
    ent_q_t q2, q3;
    logic   m2 = 1, m3 = 1;
    ent_t   h2, h3;
    logic [63:0] got_pc [10];
    logic        got_f  [10];

    always #5 clk = ~clk;

    ifid_skid_queue #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_ready(r2_ready), .f_pc(f_pc),
        .f_inst(f_inst), .f_fault(f_fault), .d_valid(d2_valid), .d_ready(d_ready),
        .d_pc(d2_pc), .d_inst(d2_inst), .d_fault(d2_fault), .flush(flush)
`ifdef IFID_PERF_EN
        , .perf_stall(p2_stall), .perf_full(p2_full), .perf_flush(p2_flush)
`endif
    );

    ifid_skid_queue #(.DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_ready(r3_ready), .f_pc(f_pc),
        .f_inst(f_inst), .f_fault(f_fault), .d_valid(d3_valid), .d_ready(d_ready),
        .d_pc(d3_pc), .d_inst(d3_inst), .d_fault(d3_fault), .flush(flush)
`ifdef IFID_PERF_EN
        , .perf_stall(p3_stall), .perf_full(p3_full), .perf_flush(p3_flush)
`endif
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // one clock of the abstract queue: pop if decode takes, then flush or push
    function automatic ent_q_t step(ent_q_t q, logic rdy);
        ent_q_t n = q;
        if (n.size() != 0 && d_ready) void'(n.pop_front());
        if (flush) n.delete();
        else if (f_valid && rdy) n.push_back('{pc: f_pc, inst: f_inst, fault: f_fault});
        return n;
    endfunction

    function automatic ent_t head(ent_q_t q);
        return (q.size() != 0) ? q[0] : '{pc: 64'h0, inst: 32'h13, fault: 1'b0};
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            q2.delete();
            q3.delete();
            m2 = 1;
            m3 = 1;
        end else begin
            q2 = step(q2, m2);
            q3 = step(q3, m3);
            m2 = q2.size() < 2;
            m3 = q3.size() < 3;
        end
    end

    initial forever begin
        @(negedge clk);
        h2 = head(q2);
        h3 = head(q3);
        chk("d2_valid", 64'(d2_valid), 64'(q2.size() != 0));
        chk("d2_pc", d2_pc, h2.pc);
        chk("d2_inst", 64'(d2_inst), 64'(h2.inst));
        chk("d2_fault", 64'(d2_fault), 64'(h2.fault));
        chk("f2_ready", 64'(r2_ready), 64'(m2));
        chk("d3_valid", 64'(d3_valid), 64'(q3.size() != 0));
        chk("d3_pc", d3_pc, h3.pc);
        chk("d3_inst", 64'(d3_inst), 64'(h3.inst));
        chk("d3_fault", 64'(d3_fault), 64'(h3.fault));
        chk("f3_ready", 64'(r3_ready), 64'(m3));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_in, n_out, cyc;
        repeat (3) tick();
        rst = 1;
        tick();
        chk("rst_f_ready", 64'(r2_ready), 64'h1);
        chk("rst_d_valid", 64'(d2_valid), 64'h0);
        chk("rst_d_inst", 64'(d2_inst), 64'h13);
        chk("rst_d_pc", d2_pc, 64'h0);

        f_valid = 1; d_ready = 0; f_pc = 64'h1000; f_inst = 32'h00500093;
        tick();
        f_pc = 64'h1004; f_inst = 32'h00A00113;
        tick();
        f_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_f_ready", 64'(r2_ready), 64'h0);
            chk("stall_d_pc", d2_pc, 64'h1000);
            tick();
        end
        d_ready = 1;
        tick();
        chk("pop1_d_pc", d2_pc, 64'h1004);
        chk("pop1_f_ready", 64'(r2_ready), 64'h1);
        tick();
        chk("pop2_d_valid", 64'(d2_valid), 64'h0);

        f_valid = 1;
        for (int i = 0; i < 20; i++) begin
            f_pc = 64'h2000 + 64'(4 * i);
            f_inst = 32'(i);
            tick();
            chk("stream_d_pc", d2_pc, 64'h2000 + 64'(4 * i));
            chk("stream_f_ready", 64'(r2_ready), 64'h1);
        end
        f_valid = 0;
        tick();

        d_ready = 0; f_valid = 1; f_pc = 64'h10;
        tick();
        f_pc = 64'h14;
        tick();
        f_pc = 64'h3000; flush = 1; d_ready = 1;
        tick();
        flush = 0; f_valid = 0; d_ready = 0;
        chk("flush_d_valid", 64'(d2_valid), 64'h0);
        chk("flush_d_inst", 64'(d2_inst), 64'h13);
        chk("flush_f_ready", 64'(r2_ready), 64'h1);
        chk("flush3_d_valid", 64'(d3_valid), 64'h0);
        tick();
        chk("flush_dropped", 64'(d2_valid), 64'h0);

        n_in = 0; n_out = 0; cyc = 0;
        while (n_out < 10 && cyc < 300) begin
            f_valid = n_in < 10;
            f_pc = 64'h4000 + 64'(4 * n_in);
            f_inst = 32'h100 + 32'(n_in);
            f_fault = n_in == 7;
            d_ready = 1'($urandom_range(0, 1));
            if (d3_valid && d_ready) begin
                got_pc[n_out] = d3_pc;
                got_f[n_out] = d3_fault;
                n_out++;
            end
            if (f_valid && r3_ready) n_in++;
            tick();
            cyc++;
        end
        f_valid = 0; f_fault = 0;
        chk("wrap_count", 64'(n_out), 64'd10);
        for (int k = 0; k < 10; k++) begin
            chk("wrap_pc", got_pc[k], 64'h4000 + 64'(4 * k));
            chk("wrap_fault", 64'(got_f[k]), 64'(k == 7));
        end
        d_ready = 1;
        repeat (4) tick();

`ifdef IFID_PERF_EN
        rst = 0; d_ready = 0;
        tick();
        rst = 1;
        tick();
        f_valid = 1; f_pc = 64'h5000;
        tick();
        f_valid = 0;
        repeat (2) tick();
        f_valid = 1; f_pc = 64'h5004;
        tick();
        f_valid = 0;
        tick();
        d_ready = 1;
        tick();
        flush = 1;
        tick();
        d_ready = 0;
        tick();
        flush = 0;
        chk("perf_stall", 64'(p2_stall), 64'd4);
        chk("perf_full", 64'(p2_full), 64'd2);
        chk("perf_flush", 64'(p2_flush), 64'd1);
        f_valid = 1; f_pc = 64'h5008;
        tick();
        f_valid = 0; flush = 1; d_ready = 1;
        tick();
        flush = 0;
        chk("perf_stall2", 64'(p2_stall), 64'd4);
        chk("perf_full2", 64'(p2_full), 64'd2);
        chk("perf_flush2", 64'(p2_flush), 64'd2);
`endif

        for (int i = 0; i < 500; i++) begin
            f_valid = $urandom_range(0, 3) != 0;
            d_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 19) == 0;
            rst = $urandom_range(0, 99) != 0;
            f_pc = {$urandom, $urandom};
            f_inst = $urandom;
            f_fault = $urandom_range(0, 7) == 0;
            tick();
        end
        rst = 1; flush = 0; f_valid = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
